// File: rtl/wb_scratchpad.sv
// Word-addressed scratchpad behind the Wishbone stream converter.
// Serves WRITE/READ accesses plus multi-cycle CLEAR and SUM sweeps.
module wb_scratchpad #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [63:0] load_recv_msg,
    input  logic        load_recv_val,
    output logic        load_recv_rdy,
    input  logic [31:0] instruction_recv_msg,
    input  logic        instruction_recv_val,
    output logic        instruction_recv_rdy,
    output logic [31:0] store_send_msg,
    output logic        store_send_val,
    input  logic        store_send_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        CLEAR,
        SUM
    } state_t;

    localparam logic [31:0]       DEPTH32 = 32'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_END = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t state, state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W:0]   cnt;
    logic [31:0]       acc;
    logic [31:0]       rd_q;
    logic [31:0]       checksum;
    logic [31:0]       resp_data;

    logic [31:0]       idx;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] widx;
    logic [4:0]        opcode;
    logic              in_range;
    logic              accept;
    logic              do_write;
    logic              do_read;
    logic              clr_last;
    logic              sum_last;
    logic              unused_bits;

    assign idx         = load_recv_msg[63:32];
    assign wdata       = load_recv_msg[31:0];
    assign widx        = idx[ADDR_W-1:0];
    assign opcode      = instruction_recv_msg[31:27];
    assign unused_bits = ^instruction_recv_msg[26:0];

    // Range check uses all 32 index bits; only low bits address memory.
    assign in_range = idx < DEPTH32;
    assign accept   = (state == IDLE) && load_recv_val
                      && instruction_recv_val;
    assign do_write = accept && (opcode == 5'd0) && in_range;
    assign do_read  = accept && (opcode == 5'd1);
    assign clr_last = (state == CLEAR) && (cnt[ADDR_W-1:0] == LAST);
    assign sum_last = (state == SUM) && (cnt == CNT_END);

    // Read response source: memory word, checksum, or zero.
    always_comb begin
        resp_data = 32'h0;
        if (in_range)
            resp_data = mem[widx];
        else if (idx == DEPTH32)
            resp_data = checksum;
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs; rdys depend only on state.
    always_comb begin
        state_nxt            = state;
        load_recv_rdy        = 1'b0;
        instruction_recv_rdy = 1'b0;
        store_send_val       = 1'b0;
        unique case (state)
            IDLE: begin
                load_recv_rdy        = 1'b1;
                instruction_recv_rdy = 1'b1;
                if (instruction_recv_val) begin
                    if (load_recv_val) begin
                        if (opcode == 5'd1)
                            state_nxt = RESP;
                    end else if (opcode == 5'd2) begin
                        state_nxt = CLEAR;
                    end else if (opcode == 5'd3) begin
                        state_nxt = SUM;
                    end
                end
            end
            RESP: begin
                store_send_val = 1'b1;
                if (store_send_rdy)
                    state_nxt = IDLE;
            end
            CLEAR: begin
                if (clr_last)
                    state_nxt = IDLE;
            end
            SUM: begin
                if (sum_last)
                    state_nxt = IDLE;
            end
        endcase
    end

    // Response register, sweep counter, accumulator and checksum.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            store_send_msg <= 32'h0;
            cnt            <= '0;
            acc            <= 32'h0;
            checksum       <= 32'h0;
        end else begin
            if (do_read)
                store_send_msg <= resp_data;
            unique case (state)
                CLEAR: begin
                    if (clr_last) begin
                        cnt      <= '0;
                        checksum <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SUM: begin
                    if (sum_last) begin
                        cnt      <= '0;
                        acc      <= 32'h0;
                        checksum <= acc + rd_q;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt != '0)
                            acc <= acc + rd_q;
                    end
                end
                default: begin
                    cnt <= '0;
                    acc <= 32'h0;
                end
            endcase
        end
    end

    // Memory array (not reset): bus writes, clear sweep, sum read port.
    always_ff @(posedge wb_clk_i) begin
        if (do_write)
            mem[widx] <= wdata;
        else if (state == CLEAR)
            mem[cnt[ADDR_W-1:0]] <= 32'h0;
        rd_q <= mem[cnt[ADDR_W-1:0]];
    end

endmodule

// File: tb/tb_wb_scratchpad.sv
// Self-checking bench for wb_scratchpad.
// Directed steps plus random traffic against an array reference model.
module tb_wb_scratchpad;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] load_msg = '0;
    logic        load_val = 1'b0;
    logic        load_rdy;
    logic [31:0] instr_msg = '0;
    logic        instr_val = 1'b0;
    logic        instr_rdy;
    logic [31:0] send_msg;
    logic        send_val;
    logic        send_rdy = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_chk = 32'h0;

    always #5 clk = ~clk;

    wb_scratchpad #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .wb_clk_i             (clk),
        .wb_rst_i             (rst),
        .load_recv_msg        (load_msg),
        .load_recv_val        (load_val),
        .load_recv_rdy        (load_rdy),
        .instruction_recv_msg (instr_msg),
        .instruction_recv_val (instr_val),
        .instruction_recv_rdy (instr_rdy),
        .store_send_msg       (send_msg),
        .store_send_val       (send_val),
        .store_send_rdy       (send_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'h0, send_val, load_rdy, instr_rdy};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] idx);
        if (idx < DEPTH)
            return model_mem[idx[ADDR_W-1:0]];
        if (idx == DEPTH)
            return model_chk;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_sum();
        logic [31:0] s = 32'h0;
        for (int i = 0; i < DEPTH; i++)
            s = s + model_mem[i];
        return s;
    endfunction

    function automatic logic [31:0] rand_idx();
        int unsigned sel = $urandom_range(0, 9);
        if (sel == 0)
            return DEPTH + $urandom_range(0, 3);
        if (sel == 1)
            return {1'b1, 31'($urandom)};
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic wr(input logic [31:0] idx, input logic [31:0] data);
        @(negedge clk);
        load_msg  = {idx, data};
        instr_msg = {5'd0, 27'h0};
        load_val  = 1'b1;
        instr_val = 1'b1;
        chk("wr_rdy", flags(), 32'h3);
        @(posedge clk);
        #1;
        load_val  = 1'b0;
        instr_val = 1'b0;
        if (idx < DEPTH)
            model_mem[idx[ADDR_W-1:0]] = data;
    endtask

    task automatic rd(input logic [31:0] idx, input int stall);
        logic [31:0] exp = model_read(idx);
        @(negedge clk);
        load_msg  = {idx, 32'($urandom)};
        instr_msg = {5'd1, 27'($urandom)};
        load_val  = 1'b1;
        instr_val = 1'b1;
        send_rdy  = 1'b0;
        chk("rd_rdy", flags(), 32'h3);
        @(posedge clk);
        #1;
        load_val  = 1'b0;
        instr_val = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rd_stall_flags", flags(), 32'h4);
            chk("rd_stall_msg", send_msg, exp);
        end
        @(negedge clk);
        send_rdy = 1'b1;
        chk("rd_val", flags(), 32'h4);
        chk("rd_msg", send_msg, exp);
        @(posedge clk);
        #1;
        send_rdy = 1'b0;
        @(negedge clk);
        chk("rd_idle", flags(), 32'h3);
    endtask

    task automatic cmd(input logic [4:0] op, input int busy,
                       input string tag);
        int n = 0;
        @(negedge clk);
        instr_msg = {op, 27'($urandom)};
        instr_val = 1'b1;
        load_val  = 1'b0;
        @(posedge clk);
        #1;
        instr_val = 1'b0;
        @(negedge clk);
        while (!instr_rdy && n < 4 * DEPTH) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n), 32'(busy));
        if (op == 5'd2) begin
            for (int i = 0; i < DEPTH; i++)
                model_mem[i] = 32'h0;
            model_chk = 32'h0;
        end else if (op == 5'd3) begin
            model_chk = model_sum();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #1;
        chk("rst_flags", flags(), 32'h3);
        chk("rst_msg", send_msg, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(DEPTH, 0);

        // defined memory contents
        cmd(5'd2, DEPTH, "clear_busy");

        // basic write/read
        wr(5, 32'hCAFE_F00D);
        rd(5, 0);
        rd(5, 4);

        // out-of-range write is dropped, alias word untouched
        wr(DEPTH + 3, 32'h1234);
        rd(DEPTH + 3, 1);
        rd(3, 0);

        // NOPs: instruction-only opcode 7, both vals opcode 2
        cmd(5'd7, 0, "nop_instr");
        @(negedge clk);
        load_msg  = {32'd5, 32'h5555_5555};
        instr_msg = {5'd2, 27'h0};
        load_val  = 1'b1;
        instr_val = 1'b1;
        @(posedge clk);
        #1;
        load_val  = 1'b0;
        instr_val = 1'b0;
        @(negedge clk);
        chk("nop_both_flags", flags(), 32'h3);
        rd(5, 0);

        // checksum of 1..4
        cmd(5'd2, DEPTH, "clear_busy2");
        for (int i = 0; i < 4; i++)
            wr(i, i + 1);
        cmd(5'd3, DEPTH + 1, "sum_busy");
        rd(DEPTH, 0);
        chk("sum_10", model_chk, 32'd10);

        // clear then sum, then wrapping sum
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        cmd(5'd2, DEPTH, "clear_busy3");
        cmd(5'd3, DEPTH + 1, "sum_busy2");
        rd(DEPTH, 0);
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        cmd(5'd3, DEPTH + 1, "sum_busy3");
        rd(DEPTH, 2);
        chk("sum_wrap", model_chk, 32'hFFFF_FFFE);

        // random traffic
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) != 0)
                wr(rand_idx(), $urandom);
            else
                rd(rand_idx(), $urandom_range(0, 2));
        end
        cmd(5'd3, DEPTH + 1, "sum_busy_rand");
        rd(DEPTH, 0);
        for (int k = 0; k < 8; k++)
            rd(rand_idx(), 0);

        // reset in the middle of a clear sweep
        wr(10, 32'hA5A5_0010);
        wr(20, 32'h5A5A_0020);
        wr(5, 32'h1111_0005);
        rd(20, 0);
        @(negedge clk);
        instr_msg = {5'd2, 27'h0};
        instr_val = 1'b1;
        @(posedge clk);
        #1;
        instr_val = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midclr_flags", flags(), 32'h3);
        chk("midclr_msg", send_msg, 32'h0);
        for (int i = 0; i < 10; i++)
            model_mem[i] = 32'h0;
        model_chk = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        rd(0, 0);
        rd(5, 0);
        rd(9, 0);
        rd(10, 0);
        rd(20, 0);
        rd(DEPTH, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_scratchpad.md
# wb_scratchpad

Word-addressed scratchpad memory directly downstream of the Wishbone-to-stream converter. It consumes the converter's load stream (index and data) and instruction stream (opcode) and performs the requested access or command. For reads it returns data on the store stream, which the converter forwards as `wbs_dat_o`. It also supports two multi-cycle maintenance commands, CLEAR and SUM, so software can zero or checksum the memory without per-word bus traffic.

## Interface
- `DEPTH`, 256: number of 32-bit words in the scratchpad; power of two, minimum 4.
- `ADDR_W`, 8: index width; must equal log2(`DEPTH`).

Ports:
- `wb_clk_i`  in  1  single clock; all state changes on its rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `load_recv_msg`  in  64  [63:32] word index; [31:0] write data.
- `load_recv_val`  in  1  load message valid.
- `load_recv_rdy`  out  1  load message accepted when val&&rdy.
- `instruction_recv_msg`  in  32  [31:27] opcode; [26:0] ignored.
- `instruction_recv_val`  in  1  instruction valid.
- `instruction_recv_rdy`  out  1  instruction accepted when val&&rdy.
- `store_send_msg`  out  32  read response data.
- `store_send_val`  out  1  response valid.
- `store_send_rdy`  in  1  response consumed when val&&rdy.

## Operation
- FSM states: IDLE, RESP, CLEAR, SUM. Reset enters IDLE.
- `load_recv_rdy` = `instruction_recv_rdy` = (state==IDLE). Both are combinational from state, with no dependence on the val inputs.
- In IDLE, a transaction is accepted according to the cases below.
  - `load_recv_val`&&`instruction_recv_val`, opcode 0 (WRITE):
    - index < DEPTH: mem[index[ADDR_W-1:0]] <= data at that edge.
    - index >= DEPTH: write dropped.
    - State stays IDLE.
  - both vals, opcode 1 (READ):
    - Latch the index and issue a synchronous read.
    - Go to RESP.
  - `instruction_recv_val` only:
    - Opcode 2 (CLEAR): go to CLEAR.
    - Opcode 3 (SUM): go to SUM.
    - Any other opcode: consumed as NOP, stay IDLE.
  - Both vals with opcode not 0 or 1: consumed as NOP.
  - `load_recv_val` alone: ignored. It cannot occur from the converter.
- RESP:
  - `store_send_val`=1 and `store_send_msg` is held stable until `store_send_rdy`.
  - On val&&rdy, return to IDLE.
  - Response data by index:
    - index < DEPTH: mem word.
    - index == DEPTH: checksum register.
    - index > DEPTH: 32'h0.
- CLEAR:
  - A sweep counter runs 0..DEPTH-1 and writes one zero word per cycle.
  - The checksum register is cleared on the last write.
  - Returns to IDLE after the write to DEPTH-1.
- SUM:
  - Sequential read of mem[0..DEPTH-1], with a 32-bit accumulator that wraps modulo 2^32.
  - The accumulator is committed to the checksum register on the final cycle, then the FSM returns to IDLE.
- Memory contents are not reset. The checksum register resets to 0.
- `store_send_msg` retains its last value outside RESP, and is 0 after reset.

## Timing
- Reset values: state IDLE, `load_recv_rdy`=1, `instruction_recv_rdy`=1, `store_send_val`=0, `store_send_msg`=0, checksum 0, sweep counter 0.
- WRITE: accepted in the same cycle val is seen. Zero-latency ack from the converter. The new data is visible to any read accepted in a later cycle.
- READ timing:
  - Accepted at cycle T.
  - `store_send_val`=1 from T+1, held until handshake at cycle T+k.
  - IDLE again at T+k+1.
  - Back-to-back reads: minimum 2 cycles each.
- CLEAR: accepted at T, busy (rdys low) for exactly DEPTH cycles T+1..T+DEPTH, IDLE at T+DEPTH+1.
- SUM: accepted at T, busy for DEPTH+1 cycles because of the read pipeline. Checksum valid from T+DEPTH+2.
- Sweep counter and index wrap: only the low ADDR_W bits address memory. The range check uses all 32 index bits.
- Asynchronous reset mid-RESP/CLEAR/SUM:
  - Immediate return to IDLE with reset outputs.
  - The pending response is discarded.
  - A partially cleared memory keeps its cleared words.
  - A partial sum is discarded.
- A store handshake and a new request cannot coincide, since rdys are low in RESP.

## Test plan
- Reset then WRITE idx 5 data 32'hCAFE_F00D, then READ idx 5: rdys high during write; `store_send_val` rises 1 cycle after read acceptance; msg = 32'hCAFE_F00D.
- READ with `store_send_rdy` held low 4 cycles: val and msg stable for all 4 cycles; rdys low throughout; IDLE exactly 1 cycle after the handshake.
- WRITE idx DEPTH+3 data 32'h1234, then READ idx DEPTH+3: memory unchanged; response 32'h0.
- Write words 0..3 = 1,2,3,4 and all other words 0; SUM; READ idx DEPTH: rdys low for DEPTH+1 cycles; response 32'd10.
- Write 32'hFFFF_FFFF to idx 0 and 1; CLEAR then SUM then READ idx DEPTH → 0; second pass without CLEAR → 32'hFFFF_FFFE (wrap).
- Assert `wb_rst_i` mid-CLEAR at sweep count 10: outputs at reset values immediately; words 0..9 read 0, word 20 keeps its prior value.
